// File: rtl/fetch_decode_pipe_pkg.sv
// rtl/fetch_decode_pipe_pkg.sv - shared constants, ID/EX bundle type and counter helper
package fetch_decode_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       memtoreg;
    logic       valid;
  } idex_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// rtl/fetch_decode_pipe_if.sv - hazard-control and stage signals between hazard unit and fetch/decode pipe
interface fetch_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            flushE;
  logic [XLEN-1:0] pcnextF;
  logic [31:0]     instrF;
  logic [4:0]      rs1D;
  logic [4:0]      rs2D;
  logic [4:0]      rdD;
  logic            regwriteD;
  logic            memtoregD;

  logic [XLEN-1:0] pcF;
  logic [31:0]     instrD;
  logic [XLEN-1:0] pcD;
  logic [XLEN-1:0] pcplus4D;
  logic            validD;
  logic            validE;
  logic [4:0]      rs1E;
  logic [4:0]      rs2E;
  logic [4:0]      rdE;
  logic            regwriteE;
  logic            memtoregE;
  logic [31:0]     stallcnt;
  logic [31:0]     flushcnt;

  modport master (
    output stallF, stallD, flushD, flushE, pcnextF, instrF,
           rs1D, rs2D, rdD, regwriteD, memtoregD,
    input  pcF, instrD, pcD, pcplus4D, validD, validE,
           rs1E, rs2E, rdE, regwriteE, memtoregE, stallcnt, flushcnt
  );

  modport slave (
    input  stallF, stallD, flushD, flushE, pcnextF, instrF,
           rs1D, rs2D, rdD, regwriteD, memtoregD,
    output pcF, instrD, pcD, pcplus4D, validD, validE,
           rs1E, rs2E, rdE, regwriteE, memtoregE, stallcnt, flushcnt
  );

endinterface

// File: rtl/fetch_decode_pipe_flopenrc.sv
// rtl/fetch_decode_pipe_flopenrc.sv - enable register with synchronous clear; clear and reset load the same value
module fetch_decode_pipe_flopenrc #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // clear outranks enable so a flush during a stall still produces a bubble
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - PC, IF/ID and ID/EX pipeline registers with stall/flush and event counters
module fetch_decode_pipe
  import fetch_decode_pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input logic               clk,
  input logic               reset,
  fetch_decode_pipe_if.slave bus
);

  localparam int IFID_W = 32 + 2 * XLEN + 1;
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

  logic [XLEN-1:0]   pc_q;
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;
  logic [31:0]       instrD_q;
  logic [XLEN-1:0]   pcD_q;
  logic [XLEN-1:0]   pcplus4D_q;
  logic              validD_q;
  idex_t             idex_d;
  logic [$bits(idex_t)-1:0] idex_raw_q;
  idex_t             idex_q;
  logic [31:0]       stallcnt_d, stallcnt_q;
  logic [31:0]       flushcnt_d, flushcnt_q;

  fetch_decode_pipe_flopenrc #(
    .WIDTH   (XLEN),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (~bus.stallF),
    .clr_i   (1'b0),
    .d_i     (bus.pcnextF),
    .q_o     (pc_q)
  );

  assign ifid_d = {bus.instrF, pc_q, pc_q + XLEN'(4), 1'b1};

  fetch_decode_pipe_flopenrc #(
    .WIDTH   (IFID_W),
    .RST_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (~bus.stallD),
    .clr_i   (bus.flushD),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign {instrD_q, pcD_q, pcplus4D_q, validD_q} = ifid_q;

  // a bubble in D must never turn into a register or load write in E
  always_comb begin
    idex_d          = '0;
    idex_d.rs1      = bus.rs1D;
    idex_d.rs2      = bus.rs2D;
    idex_d.rd       = bus.rdD;
    idex_d.regwrite = bus.regwriteD & validD_q;
    idex_d.memtoreg = bus.memtoregD & validD_q;
    idex_d.valid    = validD_q;
  end

  fetch_decode_pipe_flopenrc #(
    .WIDTH   ($bits(idex_t)),
    .RST_VAL ('0)
  ) u_idex_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (1'b1),
    .clr_i   (bus.flushE),
    .d_i     (idex_d),
    .q_o     (idex_raw_q)
  );

  assign idex_q = idex_t'(idex_raw_q);

  always_comb begin
    stallcnt_d = stallcnt_q;
    flushcnt_d = flushcnt_q;
    if (bus.stallD) begin
      stallcnt_d = sat_inc(stallcnt_q);
    end
    if (bus.flushD || bus.flushE) begin
      flushcnt_d = sat_inc(flushcnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else begin
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end

  assign bus.pcF       = pc_q;
  assign bus.instrD    = instrD_q;
  assign bus.pcD       = pcD_q;
  assign bus.pcplus4D  = pcplus4D_q;
  assign bus.validD    = validD_q;
  assign bus.validE    = idex_q.valid;
  assign bus.rs1E      = idex_q.rs1;
  assign bus.rs2E      = idex_q.rs2;
  assign bus.rdE       = idex_q.rd;
  assign bus.regwriteE = idex_q.regwrite;
  assign bus.memtoregE = idex_q.memtoreg;
  assign bus.stallcnt  = stallcnt_q;
  assign bus.flushcnt  = flushcnt_q;

endmodule

// File: doc/fetch_decode_pipe.md
FETCH_DECODE_PIPE -- requirements
Module: fetch_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC and instruction fields.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port stallF  input  1  hold PC register.
REQ-006 Port stallD  input  1  hold IF/ID register.
REQ-007 Port flushD  input  1  clear IF/ID register to bubble.
REQ-008 Port flushE  input  1  clear ID/EX register to bubble.
REQ-009 Port pcnextF  input  XLEN  next PC from fetch mux.
REQ-010 Port instrF  input  32  instruction fetched at pcF.
REQ-011 Port rs1D, rs2D, rdD  input  5 each  decoded register fields.
REQ-012 Port regwriteD, memtoregD  input  1 each  decoded control.
REQ-013 Port pcF  output  XLEN  current fetch PC.
REQ-014 Port instrD, pcD, pcplus4D  output  32/XLEN/XLEN  IF/ID contents.
REQ-015 Port validD, validE  output  1 each  stage holds a real instruction.
REQ-016 Port rs1E, rs2E, rdE  output  5 each  ID/EX register fields.
REQ-017 Port regwriteE, memtoregE  output  1 each  ID/EX control.
REQ-018 Port stallcnt, flushcnt  output  32 each  saturating event counters.

Function
REQ-019 PC register SHALL load pcnextF each cycle unless stallF=1, in which case it SHALL hold.
REQ-020 IF/ID priority SHALL be reset > flushD > stallD > load.
REQ-021 IF/ID load SHALL capture instrF, pcF, pcF+4 (XLEN-bit, wrap modulo 2^XLEN) and set validD=1.
REQ-022 IF/ID flush SHALL set instrD=32'h0000_0013 (NOP), pcD=0, pcplus4D=0, validD=0.
REQ-023 flushD=1 with stallD=1 in same cycle SHALL flush (flush wins).
REQ-024 ID/EX priority SHALL be reset > flushE > load; ID/EX has no stall input.
REQ-025 ID/EX load SHALL capture rs1D, rs2D, rdD, regwriteD, memtoregD, and validE<=validD.
REQ-026 ID/EX flush SHALL zero rs1E, rs2E, rdE, regwriteE, memtoregE, validE.
REQ-027 A stalled or flushed D-stage bubble propagating into E SHALL carry regwriteE=0 and memtoregE=0 regardless of decoded inputs when validD=0.
REQ-028 stallcnt SHALL increment by 1 each cycle stallD=1, saturating at 32'hFFFF_FFFF.
REQ-029 flushcnt SHALL increment by 1 each cycle (flushD|flushE)=1 (once per cycle, not twice), saturating at 32'hFFFF_FFFF.
REQ-030 Outputs SHALL be registered only; no combinational path from any input to any output.
REQ-031 Latency: instrF visible on instrD one cycle after capture; rdD visible on rdE one cycle later.

Reset
REQ-032 On reset: pcF=RESET_PC; IF/ID and ID/EX in flushed state (REQ-022, REQ-026); stallcnt=flushcnt=0.
REQ-033 Reset SHALL override all stall/flush inputs, including mid-stall.
REQ-034 First cycle after reset deassertion SHALL load normally (validD=1 after that edge if not flushed).

Structure
REQ-035 Shared package SHALL hold NOP_INSTR constant, default RESET_PC, and a packed struct for the ID/EX bundle (rs1, rs2, rd, regwrite, memtoreg, valid).
REQ-036 One sub-module flopenrc (enable + synchronous clear, parameterized width) SHALL implement every pipeline register; counters are local.

Verification
REQ-037 Reset then 3 free cycles, pcnextF=pcF+4 -> pcF 0,4,8,12; instrD follows instrF one cycle late; validD=1 from cycle 2.
REQ-038 stallF=stallD=flushE=1 for 2 cycles (load-use) -> pcF and instrD held, validE=0, regwriteE=0, stallcnt=2, flushcnt=2.
REQ-039 flushD=1 and stallD=1 same cycle -> instrD=32'h0000_0013, validD=0, next cycle validE=0.
REQ-040 reset asserted during stallF=1 -> pcF=RESET_PC next edge, counters 0.
REQ-041 Force stallcnt near 32'hFFFF_FFFE, hold stallD 3 cycles -> stallcnt stays 32'hFFFF_FFFF.
REQ-042 pcF=32'hFFFF_FFFC loaded -> pcplus4D=32'h0000_0000 (wrap).
